// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD line capture path.
package lcd_pkg;
  localparam int LCD_WIDTH  = 160;
  localparam int LCD_HEIGHT = 144;
  typedef logic [1:0] shade_t;
endpackage

// File: rtl/lcd_line_ram.sv
// Ping-pong line storage: two WIDTH x 2-bit banks, one write port, one registered read port.
module lcd_line_ram
  import lcd_pkg::*;
#(
  parameter int WIDTH = LCD_WIDTH,
  parameter int XW    = $clog2(LCD_WIDTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [XW-1:0] wr_addr,
  input  shade_t        wr_data,
  input  logic          rd_bank,
  input  logic [XW-1:0] rd_addr,
  output shade_t        rd_data
);
  localparam logic [XW:0] LINE_END = (XW+1)'(WIDTH);

  shade_t mem [2][WIDTH];

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clock)
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)                       rd_data <= '0;
    else if ({1'b0, rd_addr} < LINE_END) rd_data <= mem[rd_bank][rd_addr];
    else                                rd_data <= '0;
endmodule

// File: rtl/lcd_line_capture.sv
// Captures PPU pixel lines into ping-pong buffers and hands completed lines to the encoder.
// Optional LCD_CAPTURE_PALETTE_EN adds bgp input and rd_grey output (BGP-mapped grey level).
module lcd_line_capture
  import lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT,
  parameter int XW     = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  shade_t        pixel_data,
  input  logic          pixel_clock,
  input  logic          pixel_latch,
  input  logic          vsync,
  output logic          line_valid,
  output logic [7:0]    line_num,
  input  logic [XW-1:0] rd_x,
  output shade_t        rd_data,
  input  logic          line_done,
`ifdef LCD_CAPTURE_PALETTE_EN
  input  logic [7:0]    bgp,
  output logic [7:0]    rd_grey,
`endif
  output logic          frame_start,
  output logic          overrun,
  output logic          short_line
);
  localparam logic [XW:0] LINE_END  = (XW+1)'(WIDTH);
  localparam logic [7:0]  LAST_LINE = 8'(HEIGHT-1);

  logic        pclk_d, latch_d, vsync_d, armed;
  logic        pix_ev, latch_ev, vsync_ev;
  logic        pix_we, line_full, bank_free, swap;
  logic [XW:0] wr_x, px_cnt;
  logic        wr_bank;
  logic [7:0]  wr_line;

  // armed masks the first cycle after reset so a level already high is not an edge.
  always_comb begin
    pix_ev    = armed & pixel_clock & ~pclk_d;
    latch_ev  = armed & pixel_latch & ~latch_d;
    vsync_ev  = armed & vsync & ~vsync_d;
    pix_we    = pix_ev && (wr_x < LINE_END);
    px_cnt    = wr_x + (XW+1)'(pix_we);
    line_full = (px_cnt == LINE_END);
    bank_free = ~line_valid | line_done;
    swap      = latch_ev & line_full & bank_free;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      armed       <= 1'b0;
      pclk_d      <= 1'b0;
      latch_d     <= 1'b0;
      vsync_d     <= 1'b0;
      wr_x        <= '0;
      wr_bank     <= 1'b0;
      wr_line     <= '0;
      line_valid  <= 1'b0;
      line_num    <= '0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
      short_line  <= 1'b0;
    end else begin
      armed       <= 1'b1;
      pclk_d      <= pixel_clock;
      latch_d     <= pixel_latch;
      vsync_d     <= vsync;
      frame_start <= vsync_ev;
      overrun     <= latch_ev & line_full & ~bank_free;
      short_line  <= latch_ev & ~line_full;
      if (pix_we) wr_x <= px_cnt;
      if (latch_ev) begin
        wr_x <= '0;
        if (wr_line != LAST_LINE) wr_line <= wr_line + 8'd1;
      end
      // Vsync wins over a same-cycle latch; the latch already used the old wr_line.
      if (vsync_ev) begin
        wr_x    <= '0;
        wr_line <= '0;
      end
      if (swap) begin
        wr_bank    <= ~wr_bank;
        line_valid <= 1'b1;
        line_num   <= wr_line;
      end else if (line_done) begin
        line_valid <= 1'b0;
      end
    end

  lcd_line_ram #(.WIDTH(WIDTH), .XW(XW)) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (pix_we),
    .wr_bank (wr_bank),
    .wr_addr (wr_x[XW-1:0]),
    .wr_data (pixel_data),
    .rd_bank (~wr_bank),
    .rd_addr (rd_x),
    .rd_data (rd_data)
  );

`ifdef LCD_CAPTURE_PALETTE_EN
  // bgp is registered alongside the RAM read so rd_grey tracks rd_data with equal latency.
  logic [7:0] bgp_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) bgp_q <= '0;
    else          bgp_q <= bgp;
  assign rd_grey = {4{~bgp_q[{rd_data, 1'b0} +: 2]}};
`endif
endmodule

// File: tb/tb_lcd_line_capture.sv
// Directed bench for lcd_line_capture with a queue-based line model and literal spot checks.
module tb_lcd_line_capture;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] pixel_data;
  logic       pixel_clock, pixel_latch, vsync, line_done;
  logic       line_valid, frame_start, overrun, short_line;
  logic [7:0] line_num, rd_x;
  logic [1:0] rd_data;
`ifdef LCD_CAPTURE_PALETTE_EN
  logic [7:0] bgp, rd_grey, e_grey;
`endif

  always #5 clock = ~clock;

  lcd_line_capture dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pixel_data  (pixel_data),
    .pixel_clock (pixel_clock),
    .pixel_latch (pixel_latch),
    .vsync       (vsync),
    .line_valid  (line_valid),
    .line_num    (line_num),
    .rd_x        (rd_x),
    .rd_data     (rd_data),
    .line_done   (line_done),
`ifdef LCD_CAPTURE_PALETTE_EN
    .bgp         (bgp),
    .rd_grey     (rd_grey),
`endif
    .frame_start (frame_start),
    .overrun     (overrun),
    .short_line  (short_line)
  );

  int vectors = 0, miscompares = 0;

  // Model: line in progress as a queue, the presented line as an array, frame line counter.
  logic [1:0] cur[$];
  logic [1:0] rb[160];
  bit         rb_known = 0;
  int         fl = 0;
  bit         e_valid = 0, e_fs = 0, e_ov = 0, e_sl = 0, e_rd_chk = 0, cmp_en = 0;
  int         e_num = 0;
  logic [1:0] e_rd = 2'b00;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) if (cmp_en) begin
    cmp("line_valid", line_valid, e_valid);
    cmp("line_num", line_num, e_num);
    cmp("frame_start", frame_start, e_fs);
    cmp("overrun", overrun, e_ov);
    cmp("short_line", short_line, e_sl);
    if (e_rd_chk) begin
      cmp("rd_data", rd_data, e_rd);
`ifdef LCD_CAPTURE_PALETTE_EN
      cmp("rd_grey", rd_grey, e_grey);
`endif
    end
  end

  task automatic apply(input bit pix, input logic [1:0] s, input bit lat, input bit vs, input bit dn);
    bit swapped = 0;
    e_rd_chk = rb_known || rd_x >= 160;
    e_rd     = (rd_x >= 160) ? 2'b00 : rb[rd_x];
`ifdef LCD_CAPTURE_PALETTE_EN
    e_grey   = {4{~bgp[{e_rd, 1'b0} +: 2]}};
`endif
    e_fs = vs; e_ov = 0; e_sl = 0;
    if (pix && cur.size() < 160) cur.push_back(s);
    if (lat) begin
      if (cur.size() == 160) begin
        if (!e_valid || dn) begin
          foreach (rb[i]) rb[i] = cur[i];
          rb_known = 1; e_valid = 1; e_num = fl; swapped = 1;
        end else e_ov = 1;
      end else e_sl = 1;
      cur.delete();
      if (fl < 143) fl++;
    end
    if (dn && !swapped) e_valid = 0;
    if (vs) begin cur.delete(); fl = 0; end
  endtask

  task automatic step(input bit pix, input logic [1:0] s, input bit lat, input bit vs, input bit dn);
    #1;
    pixel_clock = pix; pixel_data = s; pixel_latch = lat; vsync = vs; line_done = dn;
    apply(pix, s, lat, vs, dn);
    @(negedge clock);
  endtask

  task automatic idle(); step(0, 2'b00, 0, 0, 0); endtask
  task automatic ev(input bit pix, input logic [1:0] s, input bit lat, input bit vs, input bit dn);
    step(pix, s, lat, vs, dn); idle();
  endtask

  function automatic logic [1:0] shade(input int pat, input int x);
    case (pat)
      0: return 2'(x % 4);
      1: return 2'((x * 3) % 4);
      2: return 2'(3 - x % 4);
      default: return 2'((x / 2) % 4);
    endcase
  endfunction

  task automatic pixels(input int n, input int pat);
    for (int x = 0; x < n; x++) ev(1, shade(pat, x), 0, 0, 0);
  endtask

  task automatic rd(input int x); rd_x = 8'(x); idle(); endtask

  initial begin
    reset_n = 0; pixel_clock = 1; vsync = 1; pixel_latch = 0; line_done = 0;
    pixel_data = 0; rd_x = 0;
`ifdef LCD_CAPTURE_PALETTE_EN
    bgp = 8'hE4;
`endif
    repeat (2) @(negedge clock);
    cmp("rst_valid", line_valid, 0);  cmp("rst_num", line_num, 0);
    cmp("rst_rd", rd_data, 0);        cmp("rst_fs", frame_start, 0);
    cmp("rst_ov", overrun, 0);        cmp("rst_sl", short_line, 0);
    #1 reset_n = 1; cmp_en = 1;
    repeat (3) @(negedge clock);      // levels held high across release: no events
    idle();

    // line 0: full line, presented
    pixels(160, 0);
    step(0, 0, 1, 0, 0); cmp("l0_valid", line_valid, 1); cmp("l0_num", line_num, 0); idle();
    rd(37); cmp("l0_rd37", rd_data, 2'b01);
`ifdef LCD_CAPTURE_PALETTE_EN
    rd(3); cmp("grey_11", rd_grey, 8'h00);
    rd(0); cmp("grey_00", rd_grey, 8'hFF);
`endif
    // line 1: read bank busy -> overrun
    pixels(160, 1);
    step(0, 0, 1, 0, 0); cmp("l1_ov", overrun, 1); cmp("l1_num", line_num, 0); idle();
    rd(37); cmp("l1_rd37", rd_data, 2'b01);
    // line 2: short
    pixels(100, 2);
    step(0, 0, 1, 0, 0); cmp("l2_sl", short_line, 1); cmp("l2_valid", line_valid, 1); idle();
    // line 3: last pixel, latch and line_done together
    pixels(159, 2);
    step(1, shade(2, 159), 1, 0, 1);
    cmp("l3_ov", overrun, 0); cmp("l3_valid", line_valid, 1); cmp("l3_num", line_num, 3); idle();
    rd(37); cmp("l3_rd37", rd_data, 2'b10);
    rd(159); cmp("l3_rd159", rd_data, 2'b00);
    rd(200); cmp("rd_oob", rd_data, 2'b00);
    step(0, 0, 0, 0, 1); cmp("done_clr", line_valid, 0); idle();
    ev(0, 0, 0, 0, 1);                // done while empty: ignored
    // vsync mid-line
    pixels(50, 3);
    step(0, 0, 0, 1, 0); cmp("vs_fs", frame_start, 1); idle();
    pixels(160, 3);
    step(0, 0, 1, 0, 0); cmp("vs_num", line_num, 0); idle();
    rd(37); cmp("vs_rd37", rd_data, 2'b10);
    // latch and vsync together
    ev(0, 0, 0, 0, 1);
    pixels(160, 0);
    step(0, 0, 1, 1, 0); cmp("lv_num", line_num, 1); cmp("lv_fs", frame_start, 1); idle();
    ev(0, 0, 0, 0, 1);
    pixels(160, 1);
    step(0, 0, 1, 0, 0); cmp("lv_next", line_num, 0); idle();
    // overlong line: extra pixels dropped
    ev(0, 0, 0, 0, 1);
    pixels(170, 2);
    step(0, 0, 1, 0, 0); cmp("ovl_sl", short_line, 0); cmp("ovl_num", line_num, 1); idle();
    rd(159); cmp("ovl_rd159", rd_data, 2'b00);
    rd(165); cmp("ovl_rd165", rd_data, 2'b00);
    // line counter saturation
    repeat (150) ev(0, 0, 1, 0, 0);
    ev(0, 0, 0, 0, 1);
    pixels(160, 3);
    step(0, 0, 1, 0, 0); cmp("sat_num", line_num, 143); idle();
    repeat (2) idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
